rv_rf_mp: RTL and testbench

- Parametrised multi-port integer register file for the rv core: NRD read ports, two write ports (WB0 = ALU/retire, WB1 = load/late-result) and a per-register pending scoreboard.
- Reads are registered (1-cycle latency), with write-to-read bypass and x0 hardwired to zero.
- Sits between decode (read and issue) and writeback. It replaces the fixed 2-read/1-write, 64-bit file and adds the busy tracking the hazard unit needs for load-use stalls.

---
 rtl/rv_rf_pkg.sv | 18 +
 rtl/rv_rf_sb.sv | 43 ++++
 rtl/rv_rf_mp.sv | 109 ++++++++++
 tb/tb_rv_rf_mp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_rf_pkg.sv
// Shared constants and helpers for the rv multi-port integer register file.
package rv_rf_pkg;

    localparam int unsigned XLEN_DEF    = 64;
    localparam int unsigned NREG_DEF    = 32;
    localparam int unsigned X0          = 0;
    localparam int unsigned SLICE_BUS_W = 256;

    // Field p of width w (w <= 64) from a flattened per-port bus, zero-extended.
    function automatic logic [63:0] port_slice(input logic [SLICE_BUS_W-1:0] bus,
                                               input int unsigned p,
                                               input int unsigned w);
        logic [SLICE_BUS_W-1:0] sh;
        sh = bus >> (p * w);
        return sh[63:0] & ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/rv_rf_sb.sv
// Pending-register scoreboard: one busy bit per architectural register, x0 never busy.
module rv_rf_sb
    import rv_rf_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr0_i,
    input  logic [AW-1:0]   clr0_addr_i,
    input  logic            clr1_i,
    input  logic [AW-1:0]   clr1_addr_i,
    input  logic            set_i,
    input  logic [AW-1:0]   set_addr_i,
    output logic [NREG-1:0] busy_next_o,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q;

    // Set is applied after the clears so a new producer outranks a retiring one.
    always_comb begin
        busy_next_o = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (clr0_i && clr0_addr_i == AW'(r)) busy_next_o[r] = 1'b0;
            if (clr1_i && clr1_addr_i == AW'(r)) busy_next_o[r] = 1'b0;
            if (set_i && set_addr_i == AW'(r)) busy_next_o[r] = 1'b1;
        end
        busy_next_o[X0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next_o;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/rv_rf_mp.sv
// Multi-port integer register file: NRD registered read ports with write bypass,
// two write ports and a pending scoreboard for load-use hazard detection.
module rv_rf_mp
    import rv_rf_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRD  = 2,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                wr0_en_i,
    input  logic [AW-1:0]       wr0_addr_i,
    input  logic [XLEN-1:0]     wr0_data_i,
    input  logic                wr0_clr_i,
    input  logic                wr1_en_i,
    input  logic [AW-1:0]       wr1_addr_i,
    input  logic [XLEN-1:0]     wr1_data_i,
    input  logic                wr1_clr_i,
    input  logic                set_en_i,
    input  logic [AW-1:0]       set_addr_i,
    output logic [NREG-1:0]     busy_vec_o
);

    localparam int unsigned NIDX = 1 << AW;

    // Indices that name a real, writable register: excludes x0 and any encoding >= NREG.
    function automatic logic [NIDX-1:0] idx_mask();
        logic [NIDX-1:0] m;
        m = '0;
        for (int i = X0 + 1; i < NREG; i++) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [NIDX-1:0] IDX_OK = idx_mask();

    logic            wr0_ok, wr1_ok;
    logic [NREG-1:0] busy_next;
    logic [XLEN-1:0] mem_q [NREG];

    assign wr0_ok = wr0_en_i & IDX_OK[wr0_addr_i];
    assign wr1_ok = wr1_en_i & IDX_OK[wr1_addr_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else begin
            if (wr0_ok) mem_q[wr0_addr_i] <= wr0_data_i;
            // Issued last so port 1 wins a same-index collision.
            if (wr1_ok) mem_q[wr1_addr_i] <= wr1_data_i;
        end
    end

    rv_rf_sb #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .clr0_i      (wr0_ok & wr0_clr_i),
        .clr0_addr_i (wr0_addr_i),
        .clr1_i      (wr1_ok & wr1_clr_i),
        .clr1_addr_i (wr1_addr_i),
        .set_i       (set_en_i & IDX_OK[set_addr_i]),
        .set_addr_i  (set_addr_i),
        .busy_next_o (busy_next),
        .busy_o      (busy_vec_o)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            addr_ok;
        logic [XLEN-1:0] data_d, data_q;
        logic            busy_d, busy_q;

        assign addr    = AW'(port_slice(SLICE_BUS_W'(rd_addr_i), p, AW));
        assign addr_ok = IDX_OK[addr];

        always_comb begin
            data_d = '0;
            busy_d = 1'b0;
            if (addr_ok) begin
                data_d = mem_q[addr];
                if (wr0_ok && wr0_addr_i == addr) data_d = wr0_data_i;
                if (wr1_ok && wr1_addr_i == addr) data_d = wr1_data_i;
                busy_d = busy_next[addr];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else if (rd_en_i[p]) begin
                data_q <= data_d;
                busy_q <= busy_d;
            end
        end

        assign rd_data_o[p*XLEN +: XLEN] = data_q;
        assign rd_busy_o[p]              = busy_q;
    end

endmodule

// File: tb/tb_rv_rf_mp.sv
// Scoreboard bench for rv_rf_mp: directed scenarios plus random traffic against an array model.
module tb_rv_rf_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 24;
    localparam int unsigned NRD  = 3;
    localparam int unsigned AW   = 5;

    typedef struct packed {
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
        logic [NREG-1:0]     vec;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr0_en, wr0_clr, wr1_en, wr1_clr, set_en;
    logic [AW-1:0]       wr0_addr, wr1_addr, set_addr;
    logic [XLEN-1:0]     wr0_data, wr1_data;
    logic [NREG-1:0]     busy_vec;

    int checks   = 0;
    int failures = 0;

    exp_t                exp_q[$];
    logic [XLEN-1:0]     mregs [NREG];
    logic [NREG-1:0]     mbusy;
    logic [NRD*XLEN-1:0] mdata;
    logic [NRD-1:0]      mrbusy;

    rv_rf_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .wr0_en_i   (wr0_en),
        .wr0_addr_i (wr0_addr),
        .wr0_data_i (wr0_data),
        .wr0_clr_i  (wr0_clr),
        .wr1_en_i   (wr1_en),
        .wr1_addr_i (wr1_addr),
        .wr1_data_i (wr1_data),
        .wr1_clr_i  (wr1_clr),
        .set_en_i   (set_en),
        .set_addr_i (set_addr),
        .busy_vec_o (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit ok(input logic [AW-1:0] a);
        return a != 0 && int'(a) < NREG;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        mbusy  = '0;
        mdata  = '0;
        mrbusy = '0;
        exp_q.delete();
    endtask

    task automatic idle();
        rd_en  = '0; rd_addr = '0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0; wr0_clr = 1'b0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0; wr1_clr = 1'b0;
        set_en = 1'b0; set_addr = '0;
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic read_all(input logic [AW-1:0] a);
        rd_en = '1;
        for (int p = 0; p < NRD; p++) set_ra(p, a);
    endtask

    // Model: a read sees the register file as it stands after this cycle's writes.
    task automatic step();
        exp_t e;
        if (wr0_en && ok(wr0_addr)) mregs[wr0_addr] = wr0_data;
        if (wr1_en && ok(wr1_addr)) mregs[wr1_addr] = wr1_data;
        if (wr0_en && wr0_clr && ok(wr0_addr)) mbusy[wr0_addr] = 1'b0;
        if (wr1_en && wr1_clr && ok(wr1_addr)) mbusy[wr1_addr] = 1'b0;
        if (set_en && ok(set_addr)) mbusy[set_addr] = 1'b1;
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0] a;
            a = rd_addr[p*AW +: AW];
            if (rd_en[p]) begin
                mdata[p*XLEN +: XLEN] = ok(a) ? mregs[a] : '0;
                mrbusy[p]             = ok(a) ? mbusy[a] : 1'b0;
            end
        end
        e.data = mdata;
        e.busy = mrbusy;
        e.vec  = mbusy;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_idx();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, 7));
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_data", 128'(rd_data), 128'(e.data));
            check("rd_busy", 128'(rd_busy), 128'(e.busy));
            check("busy_vec", 128'(busy_vec), 128'(e.vec));
        end
    end

    initial begin
        idle();
        model_reset();
        #1 rst = 1'b1;
        #2;
        check("reset_rd_data", 128'(rd_data), 128'(0));
        check("reset_rd_busy", 128'(rd_busy), 128'(0));
        check("reset_busy_vec", 128'(busy_vec), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read, and x0 stays zero.
        idle(); wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h1234; step();
        idle(); rd_en = 3'b001; set_ra(0, 5'd3); step();
        idle(); wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF; step();
        idle(); read_all(5'd0); step();

        // Same-cycle bypass on every port, then a two-port collision.
        idle(); wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hA5A5; read_all(5'd7); step();
        idle(); wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h22; read_all(5'd9); step();
        idle(); rd_en = 3'b010; set_ra(1, 5'd9); step();

        // Scoreboard set, clear, set-beats-clear, set to x0.
        idle(); set_en = 1'b1; set_addr = 5'd4; step();
        idle(); wr1_en = 1'b1; wr1_clr = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h44;
        read_all(5'd4); step();
        idle(); set_en = 1'b1; set_addr = 5'd4; wr0_en = 1'b1; wr0_clr = 1'b1;
        wr0_addr = 5'd4; wr0_data = 32'h45; read_all(5'd4); step();
        idle(); set_en = 1'b1; set_addr = 5'd0; step();

        // Top register and out-of-range indices.
        idle(); wr0_en = 1'b1; wr0_addr = 5'd23; wr0_data = 32'hCAFEBABE; step();
        idle(); read_all(5'd23); step();
        idle(); wr1_en = 1'b1; wr1_addr = 5'd26; wr1_data = 32'hBAD; set_en = 1'b1;
        set_addr = 5'd26; read_all(5'd26); step();
        idle(); rd_en = 3'b100; set_ra(2, 5'd26); step();

        // Mid-run reset wipes data, busy and scoreboard at once.
        idle(); wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD; step();
        idle(); set_en = 1'b1; set_addr = 5'd5; read_all(5'd5); step();
        rst = 1'b1;
        #1;
        check("midreset_rd_data", 128'(rd_data), 128'(0));
        check("midreset_rd_busy", 128'(rd_busy), 128'(0));
        check("midreset_busy_vec", 128'(busy_vec), 128'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(); read_all(5'd5); step();

        repeat (2000) begin
            rd_en = NRD'($urandom);
            for (int p = 0; p < NRD; p++) set_ra(p, rand_idx());
            wr0_en   = ($urandom_range(0, 1) == 1);
            wr0_addr = rand_idx();
            wr0_data = $urandom;
            wr0_clr  = ($urandom_range(0, 2) == 0);
            wr1_en   = ($urandom_range(0, 1) == 1);
            wr1_addr = rand_idx();
            wr1_data = $urandom;
            wr1_clr  = ($urandom_range(0, 2) == 0);
            set_en   = ($urandom_range(0, 2) == 0);
            set_addr = rand_idx();
            step();
        end

        idle();
        step();
        @(negedge clk);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
